// File: rtl/cache_pkg.sv
// Shared encodings for the single-line cache storage block.
package cache_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_FILL  = 2'b10,
        OP_INV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/cache_line_word_array.sv
// WORDS x DATA_W register file: one write port, one combinational read port,
// synchronous active-low clear.
module cache_word_array #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned WORDS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     we,
    input  logic [$clog2(WORDS)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(WORDS)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem_q [WORDS];
    logic [DATA_W-1:0] mem_d [WORDS];

    always_comb begin
        mem_d = mem_q;
        if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < WORDS; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cache_line.sv
// One cache line (data words, tag, valid, dirty) serving read/write/fill/
// invalidate requests with a one-cycle ack from the DONE state.
module cache_line
    import cache_pkg::*;
#(
    parameter  int unsigned DATA_W = 16,
    parameter  int unsigned WORDS  = 4,
    parameter  int unsigned TAG_W  = 8,
    localparam int unsigned OFF_W  = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        op,
    input  logic [TAG_W-1:0]  tag_in,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              fill_valid,
    input  logic [DATA_W-1:0] fill_data,
    output logic [DATA_W-1:0] data_out,
    output logic              hit,
    output logic              valid,
    output logic              dirty,
    output logic [TAG_W-1:0]  tag_out,
    output logic              busy,
    output logic              ack
);

    state_e            state_q, state_d;
    logic [OFF_W-1:0]  cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic              valid_q, valid_d;
    logic              dirty_q, dirty_d;
    logic              hit_q, hit_d;
    logic [DATA_W-1:0] dout_q, dout_d;

    logic              we;
    logic [OFF_W-1:0]  waddr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              match;

    cache_word_array #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS)
    ) u_array (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (offset),
        .rdata (rdata)
    );

    assign match = valid_q && (tag_in == tag_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        hit_d   = hit_q;
        dout_d  = dout_q;
        we      = 1'b0;
        waddr   = offset;
        wdata   = data_in;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    case (op)
                        OP_READ: begin
                            hit_d   = match;
                            if (match) begin
                                dout_d = rdata;
                            end
                            state_d = S_DONE;
                        end
                        OP_WRITE: begin
                            hit_d   = match;
                            if (match) begin
                                we      = 1'b1;
                                dirty_d = 1'b1;
                            end
                            state_d = S_DONE;
                        end
                        OP_FILL: begin
                            valid_d = 1'b0;
                            dirty_d = 1'b0;
                            tag_d   = tag_in;
                            cnt_d   = '0;
                            hit_d   = 1'b0;
                            state_d = S_FILL;
                        end
                        default: begin
                            valid_d = 1'b0;
                            dirty_d = 1'b0;
                            hit_d   = 1'b0;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_FILL: begin
                // Beats land at the burst counter; gaps simply hold it.
                if (fill_valid) begin
                    we    = 1'b1;
                    waddr = cnt_q;
                    wdata = fill_data;
                    cnt_d = cnt_q + OFF_W'(1);
                    if (cnt_q == OFF_W'(WORDS - 1)) begin
                        valid_d = 1'b1;
                        dirty_d = 1'b0;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            valid_q <= 1'b0;
            dirty_q <= 1'b0;
            hit_q   <= 1'b0;
            dout_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            hit_q   <= hit_d;
            dout_q  <= dout_d;
        end
    end

    assign data_out = dout_q;
    assign hit      = hit_q;
    assign valid    = valid_q;
    assign dirty    = dirty_q;
    assign tag_out  = tag_q;
    assign busy     = (state_q != S_IDLE);
    assign ack      = (state_q == S_DONE);

endmodule

// File: tb/tb_cache_line.sv
// Directed plus randomized checks of cache_line against a simple line model.
module tb_cache_line;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned WORDS  = 4;
    localparam int unsigned TAG_W  = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [TAG_W-1:0]  tag_in = '0;
    logic [1:0]        offset = '0;
    logic [DATA_W-1:0] data_in = '0;
    logic              fill_valid = 1'b0;
    logic [DATA_W-1:0] fill_data = '0;
    logic [DATA_W-1:0] data_out;
    logic              hit, valid, dirty, busy, ack;
    logic [TAG_W-1:0]  tag_out;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural line model
    logic [DATA_W-1:0] m_mem [WORDS];
    logic [TAG_W-1:0]  m_tag;
    logic              m_valid, m_dirty, m_hit;
    logic [DATA_W-1:0] m_dout;

    cache_line #(
        .DATA_W (DATA_W),
        .WORDS  (WORDS),
        .TAG_W  (TAG_W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .op         (op),
        .tag_in     (tag_in),
        .offset     (offset),
        .data_in    (data_in),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .data_out   (data_out),
        .hit        (hit),
        .valid      (valid),
        .dirty      (dirty),
        .tag_out    (tag_out),
        .busy       (busy),
        .ack        (ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < WORDS; i++) m_mem[i] = '0;
        m_tag = '0; m_valid = 0; m_dirty = 0; m_hit = 0; m_dout = '0;
    endtask

    task automatic chk_line(input string name);
        chk({name, ".hit"},   hit,      m_hit);
        chk({name, ".dout"},  data_out, m_dout);
        chk({name, ".valid"}, valid,    m_valid);
        chk({name, ".dirty"}, dirty,    m_dirty);
        chk({name, ".tag"},   tag_out,  m_tag);
    endtask

    // Single read/write/invalidate request; ack expected one cycle later.
    task automatic do_req(input logic [1:0] op_v, input logic [7:0] t,
                          input logic [1:0] off, input logic [15:0] d, input string name);
        logic m;
        @(negedge clk);
        chk({name, ".idle_busy"}, busy, 0);
        enable = 1; op = op_v; tag_in = t; offset = off; data_in = d;
        m = m_valid && (t == m_tag);
        case (op_v)
            2'b00: begin m_hit = m; if (m) m_dout = m_mem[off]; end
            2'b01: begin m_hit = m; if (m) begin m_mem[off] = d; m_dirty = 1; end end
            2'b11: begin m_valid = 0; m_dirty = 0; m_hit = 0; end
            default: ;
        endcase
        @(posedge clk);
        #1;
        enable = 1'($urandom); op = 2'($urandom); data_in = 16'($urandom);
        @(negedge clk);
        chk({name, ".ack"},  ack,  1);
        chk({name, ".busy"}, busy, 1);
        chk_line(name);
        @(posedge clk);
        #1 enable = 0;
        @(negedge clk);
        chk({name, ".ack_end"}, ack, 0);
    endtask

    // Fill burst; stall_b gets one gap before it, rnd adds random gaps.
    task automatic do_fill(input logic [7:0] t, input logic [15:0] b0, input logic [15:0] b1,
                           input logic [15:0] b2, input logic [15:0] b3,
                           input int stall_b, input bit rnd, input string name);
        logic [15:0] beats [4];
        int stalls;
        beats[0] = b0; beats[1] = b1; beats[2] = b2; beats[3] = b3;
        @(negedge clk);
        enable = 1; op = 2'b10; tag_in = t;
        @(posedge clk);
        m_valid = 0; m_dirty = 0; m_tag = t; m_hit = 0;
        #1;
        for (int b = 0; b < 4; b++) begin
            stalls = (b == stall_b) ? 1 : (rnd ? int'($urandom_range(0, 2)) : 0);
            repeat (stalls) begin
                @(negedge clk);
                fill_valid = 0; enable = 1'($urandom); op = 2'($urandom);
                chk({name, ".stall_busy"}, busy, 1);
                chk({name, ".stall_ack"},  ack,  0);
                @(posedge clk);
            end
            @(negedge clk);
            fill_valid = 1; fill_data = beats[b];
            enable = 1'($urandom); op = 2'($urandom); data_in = 16'($urandom);
            chk({name, ".beat_busy"},  busy,  1);
            chk({name, ".beat_ack"},   ack,   0);
            chk({name, ".beat_valid"}, valid, 0);
            chk({name, ".beat_tag"},   tag_out, t);
            @(posedge clk);
            m_mem[b] = beats[b];
        end
        #1 fill_valid = 0;
        m_valid = 1;
        @(negedge clk);
        chk({name, ".ack"},  ack,  1);
        chk({name, ".busy"}, busy, 1);
        chk_line(name);
        @(posedge clk);
        #1 enable = 0;
        @(negedge clk);
        chk({name, ".ack_end"}, ack, 0);
        chk({name, ".busy_end"}, busy, 0);
    endtask

    initial begin
        logic [7:0] tags [3];
        int r;
        tags[0] = 8'h3C; tags[1] = 8'h3D; tags[2] = 8'h55;
        model_reset();

        repeat (2) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        chk("reset.busy", busy, 0);
        chk("reset.ack",  ack,  0);
        chk_line("reset");

        do_req(2'b00, 8'h00, 2'd0, 16'h0, "rd_empty");
        do_fill(8'h3C, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 2, 0, "fill1");
        for (int o = 0; o < 4; o++) do_req(2'b00, 8'h3C, 2'(o), 16'h0, "rd_hit");
        do_req(2'b00, 8'h3D, 2'd2, 16'h0, "rd_miss");
        do_req(2'b01, 8'h3C, 2'd1, 16'hBEEF, "wr_hit");
        do_req(2'b00, 8'h3C, 2'd1, 16'h0, "rd_beef");
        do_req(2'b01, 8'h55, 2'd1, 16'hDEAD, "wr_miss");
        do_req(2'b00, 8'h3C, 2'd1, 16'h0, "rd_after_miss");
        do_req(2'b11, 8'h3C, 2'd0, 16'h0, "inv");
        do_req(2'b00, 8'h3C, 2'd0, 16'h0, "rd_after_inv");

        // Abort a fill with reset after two beats
        @(negedge clk);
        enable = 1; op = 2'b10; tag_in = 8'hA5;
        @(posedge clk);
        #1 enable = 0;
        for (int b = 0; b < 2; b++) begin
            @(negedge clk); fill_valid = 1; fill_data = 16'hC0DE + 16'(b);
            @(posedge clk);
        end
        @(negedge clk);
        rst = 0; enable = 1; fill_valid = 1;
        @(posedge clk);
        model_reset();
        @(negedge clk);
        chk("abort.busy", busy, 0);
        chk("abort.ack",  ack,  0);
        chk_line("abort");
        for (int i = 0; i < WORDS; i++) chk("abort.word", dut.u_array.mem_q[i], 0);
        rst = 1; enable = 0; fill_valid = 0;
        repeat (3) begin
            @(negedge clk);
            chk("abort.no_ack", ack, 0);
        end

        // Randomized traffic
        do_fill(8'h3C, 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 1, "rfill0");
        for (int n = 0; n < 80; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                do_fill(tags[$urandom_range(0, 2)], 16'($urandom), 16'($urandom),
                        16'($urandom), 16'($urandom), -1, 1, "rfill");
            else if (r == 1)
                do_req(2'b11, tags[$urandom_range(0, 2)], 2'($urandom), 16'($urandom), "rinv");
            else if (r < 6)
                do_req(2'b00, tags[$urandom_range(0, 2)], 2'($urandom), 16'($urandom), "rrd");
            else
                do_req(2'b01, tags[$urandom_range(0, 2)], 2'($urandom), 16'($urandom), "rwr");
        end

        // enable held high: a read is accepted every other cycle
        do_fill(8'h77, 16'hA0A0, 16'hB1B1, 16'hC2C2, 16'hD3D3, -1, 0, "bfill");
        @(negedge clk);
        enable = 1; op = 2'b00; tag_in = 8'h77; offset = 2'd3;
        m_hit = 1; m_dout = 16'hD3D3;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("b2b.ack", ack, (c % 2 == 0) ? 1 : 0);
            chk_line("b2b");
        end
        enable = 0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
